// File: rtl/usb_rx_bit_decoder.sv
// usb_rx_bit_decoder: full-speed USB receive path recovering bit timing from D+/D-,
// with NRZI decode, SYNC detection, bit unstuffing, LSB-first byte assembly and EOP detection.
module usb_rx_bit_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus_in,
  input  logic       d_minus_in,
  input  logic       rcv_enable,
  output logic [7:0] rcv_data,
  output logic       byte_valid,
  output logic       packet_active,
  output logic       eop_detected,
  output logic       stuff_error
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int SW = $clog2(STUFF_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} state_t;
  state_t state, state_n;
  logic dp_meta, dp_sync, dp_prev, dm_meta, dm_sync;
  logic [TW-1:0] timer;
  logic prev_level, prev_level_n;
  logic [7:0] shreg, shreg_n, shifted;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [SW-1:0] stuff_cnt, stuff_cnt_n;
  logic line_edge, sample, se0, bit_val, byte_n, eop_n, serr_n;
  assign line_edge = dp_sync ^ dp_prev;
  assign sample = timer == TW'(SAMPLE_POINT) && !line_edge;
  assign se0 = !dp_sync && !dm_sync;
  // SE1 reads as J because only D+ carries the level
  assign bit_val = dp_sync == prev_level;
  assign shifted = {bit_val, shreg[7:1]};
  assign packet_active = state != IDLE;
  always_comb begin
    state_n = state;
    prev_level_n = (sample && !se0) ? dp_sync : prev_level;
    shreg_n = shreg;
    bit_cnt_n = bit_cnt;
    stuff_cnt_n = stuff_cnt;
    byte_n = 1'b0;
    eop_n = 1'b0;
    serr_n = 1'b0;
    case (state)
      IDLE: if (line_edge && !dp_sync) begin
        state_n = SYNC;
        prev_level_n = 1'b1;
        bit_cnt_n = '0;
        stuff_cnt_n = '0;
      end
      SYNC: if (sample) begin
        if (se0) state_n = IDLE;
        else begin
          shreg_n = shifted;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = shifted == 8'h80 ? DATA : IDLE;
            stuff_cnt_n = SW'(1);
          end
        end
      end
      DATA: if (sample) begin
        if (se0) state_n = EOP;
        else if (stuff_cnt == SW'(STUFF_LIMIT)) begin
          serr_n = bit_val;
          state_n = bit_val ? IDLE : DATA;
          stuff_cnt_n = '0;
        end else begin
          shreg_n = shifted;
          bit_cnt_n = bit_cnt + 3'd1;
          stuff_cnt_n = bit_val ? stuff_cnt + SW'(1) : '0;
          byte_n = bit_cnt == 3'd7;
        end
      end
      EOP: if (sample && !se0) begin
        eop_n = dp_sync;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (!rcv_enable) begin
      state_n = IDLE;
      byte_n = 1'b0;
      eop_n = 1'b0;
      serr_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {dp_meta, dp_sync, dp_prev} <= 3'b111;
      {dm_meta, dm_sync} <= 2'b00;
      timer <= '0;
      state <= IDLE;
      prev_level <= 1'b1;
      shreg <= '0;
      bit_cnt <= '0;
      stuff_cnt <= '0;
      rcv_data <= '0;
      byte_valid <= 1'b0;
      eop_detected <= 1'b0;
      stuff_error <= 1'b0;
    end else begin
      {dp_meta, dp_sync, dp_prev} <= {d_plus_in, dp_meta, dp_sync};
      {dm_meta, dm_sync} <= {d_minus_in, dm_meta};
      timer <= (line_edge || timer == TW'(CLKS_PER_BIT - 1)) ? '0 : timer + TW'(1);
      state <= state_n;
      prev_level <= prev_level_n;
      shreg <= shreg_n;
      bit_cnt <= bit_cnt_n;
      stuff_cnt <= stuff_cnt_n;
      if (byte_n) rcv_data <= shifted;
      byte_valid <= byte_n;
      eop_detected <= eop_n;
      stuff_error <= serr_n;
    end
  end
endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// tb_usb_rx_bit_decoder: drives encoded USB packets onto D+/D- and checks decoded bytes and strobes.
module tb_usb_rx_bit_decoder;
  logic clk = 1'b0;
  logic rst, d_plus_in, d_minus_in, rcv_enable;
  logic [7:0] rcv_data;
  logic byte_valid, packet_active, eop_detected, stuff_error;
  int errors = 0, checks = 0;
  logic [7:0] got[$];
  logic [7:0] pkt[$];
  int n_eop, n_serr, n_bad;
  logic pbv = 1'b0, peop = 1'b0, pserr = 1'b0;

  typedef struct {
    string name;
    logic [7:0] sync;
    int n;
    logic [7:0] d[3];
    int abort;
    bit en;
    bit eop;
    int pa, pb;
    int exp_n;
    logic [7:0] e[3];
    int exp_eop, exp_serr;
  } vec_t;
  vec_t v[8];

  always #5 clk = ~clk;

  usb_rx_bit_decoder dut (
    .clk(clk), .rst(rst), .d_plus_in(d_plus_in), .d_minus_in(d_minus_in),
    .rcv_enable(rcv_enable), .rcv_data(rcv_data), .byte_valid(byte_valid),
    .packet_active(packet_active), .eop_detected(eop_detected), .stuff_error(stuff_error)
  );

  always @(posedge clk) begin
    #1;
    if (byte_valid) got.push_back(rcv_data);
    if (eop_detected) n_eop++;
    if (stuff_error) n_serr++;
    if ((byte_valid && (pbv || eop_detected)) || (eop_detected && peop) || (stuff_error && pserr)) n_bad++;
    pbv = byte_valid;
    peop = eop_detected;
    pserr = stuff_error;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear();
    got.delete();
    n_eop = 0;
    n_serr = 0;
    n_bad = 0;
  endtask

  task automatic line(input logic dp, input logic dm, input int clks);
    d_plus_in = dp;
    d_minus_in = dm;
    repeat (clks) @(negedge clk);
  endtask

  // Transmitter view: SYNC, stuffed data, optional run of 7 raw ones before byte 'abort', EOP, idle.
  task automatic send(input logic [7:0] sync, input int abort, input bit eop, input int pa, input int pb);
    bit bits[$];
    int run = 0;
    logic lvl = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bits.push_back(sync[i]);
      run = sync[i] ? run + 1 : 0;
    end
    for (int j = 0; j < pkt.size() && j != abort; j++)
      for (int i = 0; i < 8; i++) begin
        bits.push_back(pkt[j][i]);
        run = pkt[j][i] ? run + 1 : 0;
        if (run == 6) begin
          bits.push_back(1'b0);
          run = 0;
        end
      end
    if (abort >= 0) repeat (7) bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i++) begin
      lvl = bits[i] ? lvl : ~lvl;
      line(lvl, ~lvl, (i % 2) ? pb : pa);
    end
    if (eop) begin
      line(1'b0, 1'b0, pa);
      line(1'b0, 1'b0, pb);
      line(1'b1, 1'b0, pa);
    end
    line(1'b1, 1'b0, 40);
  endtask

  // SYNC pattern followed by nz decoded zeros, at 8 clocks per bit, leaving the packet open
  task automatic lead(input logic [7:0] sync, input int nz);
    logic lvl = 1'b1;
    for (int i = 0; i < 8 + nz; i++) begin
      lvl = (i < 8 && sync[i]) ? lvl : ~lvl;
      line(lvl, ~lvl, 8);
    end
  endtask

  initial begin
    rst = 1'b1;
    d_plus_in = 1'b1;
    d_minus_in = 1'b0;
    rcv_enable = 1'b1;
    v[0] = '{"basic", 8'h80, 1, '{8'hA5, 8'h00, 8'h00}, -1, 1'b1, 1'b1, 8, 8, 1, '{8'hA5, 8'h00, 8'h00}, 1, 0};
    v[1] = '{"stuffing", 8'h80, 2, '{8'hFF, 8'h00, 8'h00}, -1, 1'b1, 1'b1, 8, 8, 2, '{8'hFF, 8'h00, 8'h00}, 1, 0};
    v[2] = '{"jitter", 8'h80, 3, '{8'h3C, 8'h81, 8'h7E}, -1, 1'b1, 1'b1, 7, 9, 3, '{8'h3C, 8'h81, 8'h7E}, 1, 0};
    v[3] = '{"violation", 8'h80, 0, '{8'h00, 8'h00, 8'h00}, 0, 1'b1, 1'b1, 8, 8, 0, '{8'h00, 8'h00, 8'h00}, 0, 1};
    v[4] = '{"after violation", 8'h80, 1, '{8'hA5, 8'h00, 8'h00}, -1, 1'b1, 1'b1, 8, 8, 1, '{8'hA5, 8'h00, 8'h00}, 1, 0};
    v[5] = '{"disabled", 8'h80, 1, '{8'hA5, 8'h00, 8'h00}, -1, 1'b0, 1'b1, 8, 8, 0, '{8'h00, 8'h00, 8'h00}, 0, 0};
    v[6] = '{"bad sync", 8'h00, 0, '{8'h00, 8'h00, 8'h00}, -1, 1'b1, 1'b0, 8, 8, 0, '{8'h00, 8'h00, 8'h00}, 0, 0};
    v[7] = '{"jitter 9/7", 8'h80, 2, '{8'h5A, 8'hC3, 8'h00}, -1, 1'b1, 1'b1, 9, 7, 2, '{8'h5A, 8'hC3, 8'h00}, 1, 0};
    repeat (2) @(negedge clk);
    check("reset rcv_data", rcv_data, 0);
    check("reset byte_valid", byte_valid, 0);
    check("reset eop_detected", eop_detected, 0);
    check("reset stuff_error", stuff_error, 0);
    check("reset packet_active", packet_active, 0);
    rst = 1'b0;
    line(1'b1, 1'b0, 16);

    for (int t = 0; t < 8; t++) begin
      rcv_enable = v[t].en;
      pkt.delete();
      for (int i = 0; i < v[t].n; i++) pkt.push_back(v[t].d[i]);
      clear();
      send(v[t].sync, v[t].abort, v[t].eop, v[t].pa, v[t].pb);
      check({v[t].name, " byte count"}, got.size(), v[t].exp_n);
      for (int i = 0; i < v[t].exp_n && i < got.size(); i++)
        check($sformatf("%s data[%0d]", v[t].name, i), got[i], v[t].e[i]);
      check({v[t].name, " eop count"}, n_eop, v[t].exp_eop);
      check({v[t].name, " stuff_error count"}, n_serr, v[t].exp_serr);
      check({v[t].name, " strobe width"}, n_bad, 0);
      check({v[t].name, " packet_active idle"}, packet_active, 0);
      rcv_enable = 1'b1;
    end

    clear();
    lead(8'h80, 3);
    check("mid-byte packet_active before reset", packet_active, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid-byte reset rcv_data", rcv_data, 0);
    check("mid-byte reset packet_active", packet_active, 0);
    check("mid-byte reset byte_valid", byte_valid, 0);
    rst = 1'b0;
    line(1'b1, 1'b0, 80);
    check("after reset byte count", got.size(), 0);
    check("after reset eop count", n_eop, 0);

    clear();
    lead(8'h80, 3);
    check("enable drop packet_active before", packet_active, 1);
    rcv_enable = 1'b0;
    @(negedge clk);
    check("enable drop packet_active next cycle", packet_active, 0);
    line(1'b0, 1'b1, 8);
    line(1'b1, 1'b0, 32);
    line(1'b0, 1'b0, 16);
    line(1'b1, 1'b0, 48);
    check("enable drop byte count", got.size(), 0);
    check("enable drop eop count", n_eop, 0);
    rcv_enable = 1'b1;

    clear();
    lead(8'h00, 0);
    line(1'b1, 1'b0, 8);
    check("bad sync packet_active within a bit", packet_active, 0);
    check("bad sync strobes", got.size() + n_eop + n_serr, 0);
    line(1'b1, 1'b0, 24);

    for (int r = 0; r < 24; r++) begin
      int n, pa, ab, k;
      logic [7:0] x;
      logic [7:0] exp_q[$];
      n = $urandom_range(1, 3);
      pa = $urandom_range(7, 9);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n)) : -1;
      pkt.delete();
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 3);
        x = (k == 0) ? 8'hFF : (k == 1) ? 8'h7E : 8'($urandom);
        pkt.push_back(x);
        if (ab < 0 || i < ab) exp_q.push_back(x);
      end
      clear();
      send(8'h80, ab, 1'b1, pa, 16 - pa);
      check($sformatf("rand%0d byte count", r), got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
        check($sformatf("rand%0d data[%0d]", r, i), got[i], exp_q[i]);
      check($sformatf("rand%0d eop count", r), n_eop, (ab < 0) ? 1 : 0);
      check($sformatf("rand%0d stuff_error count", r), n_serr, (ab < 0) ? 0 : 1);
      check($sformatf("rand%0d strobe width", r), n_bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
